// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage: FSM states, instruction
// field positions, jump encodings and reset values.
package hack_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StMread,
    StAlu,
    StMwrite
  } state_e;

  // Instruction field positions
  localparam int unsigned I_BIT    = 15;
  localparam int unsigned A_BIT    = 12;
  localparam int unsigned CTRL_MSB = 11;
  localparam int unsigned CTRL_LSB = 6;
  localparam int unsigned D1_BIT   = 5;
  localparam int unsigned D2_BIT   = 4;
  localparam int unsigned D3_BIT   = 3;
  localparam int unsigned JMP_MSB  = 2;
  localparam int unsigned JMP_LSB  = 0;

  // Jump codes in IR[2:0] = {j1 (lt), j2 (eq), j3 (gt)}
  localparam logic [2:0] JGT = 3'b001;
  localparam logic [2:0] JEQ = 3'b010;
  localparam logic [2:0] JGE = 3'b011;
  localparam logic [2:0] JLT = 3'b100;
  localparam logic [2:0] JNE = 3'b101;
  localparam logic [2:0] JLE = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  localparam state_e      RST_STATE = StFetch;
  localparam logic [15:0] RST_WORD  = 16'h0000;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Instruction and data memory handshakes of the Hack CPU control stage.
interface hack_cpu_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_rdata;

  logic              dmem_re;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output dmem_re, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  dmem_re, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/hack_jump_unit.sv
// Jump condition evaluation from the C-instruction jump bits and ALU flags.
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU fetch/decode/register stage; drives the external ALU and performs
// writeback and jump resolution over handshaked instruction/data memories.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  hack_cpu_ctrl_if.master   bus,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_retired
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q, d_q, a_old_q, m_q, result_q, ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic              take_q;
  logic              imem_req_q, dmem_re_q, dmem_we_q, retired_q;
  logic              take;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_tgt;

  hack_jump_unit u_jump (
    .j   (ir_q[JMP_MSB:JMP_LSB]),
    .zr  (alu_zr),
    .ng  (alu_ng),
    .take(take)
  );

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign jump_tgt = a_old_q[ADDR_W-1:0];

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_re    = dmem_re_q;
  assign bus.dmem_we    = dmem_we_q;
  // Memory address comes from the snapshot so an A write cannot move it.
  assign bus.dmem_addr  = a_old_q[ADDR_W-1:0];
  assign bus.dmem_wdata = result_q;

  assign alu_x = d_q;
  assign alu_y = ir_q[A_BIT] ? m_q : a_old_q;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[CTRL_MSB:CTRL_LSB];

  assign pc            = pc_q;
  assign instr_retired = retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      a_q        <= DATA_W'(RST_WORD);
      d_q        <= DATA_W'(RST_WORD);
      a_old_q    <= DATA_W'(RST_WORD);
      m_q        <= DATA_W'(RST_WORD);
      result_q   <= DATA_W'(RST_WORD);
      ir_q       <= DATA_W'(RST_WORD);
      pc_q       <= '0;
      take_q     <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_re_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      retired_q  <= 1'b0;
    end else begin
      retired_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          // The first cycle after reset only raises the request.
          if (imem_req_q && bus.imem_valid) begin
            ir_q       <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= StExec;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        StExec: begin
          if (!ir_q[I_BIT]) begin
            a_q        <= DATA_W'(ir_q[DATA_W-2:0]);
            pc_q       <= pc_inc;
            retired_q  <= 1'b1;
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end else begin
            a_old_q <= a_q;
            if (ir_q[A_BIT]) begin
              dmem_re_q <= 1'b1;
              state_q   <= StMread;
            end else begin
              state_q <= StAlu;
            end
          end
        end
        StMread: begin
          if (bus.dmem_ready) begin
            m_q       <= bus.dmem_rdata;
            dmem_re_q <= 1'b0;
            state_q   <= StAlu;
          end
        end
        StAlu: begin
          result_q <= alu_o;
          take_q   <= take;
          if (ir_q[D1_BIT]) a_q <= alu_o;
          if (ir_q[D2_BIT]) d_q <= alu_o;
          if (ir_q[D3_BIT]) begin
            dmem_we_q <= 1'b1;
            state_q   <= StMwrite;
          end else begin
            pc_q       <= take ? jump_tgt : pc_inc;
            retired_q  <= 1'b1;
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StMwrite: begin
          if (bus.dmem_ready) begin
            dmem_we_q  <= 1'b0;
            pc_q       <= take_q ? jump_tgt : pc_inc;
            retired_q  <= 1'b1;
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end
        end
        default: begin
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end
      endcase
    end
  end

endmodule
